// File: rtl/score_scanner.sv
// score_scanner: snapshots the board and counts white/black/empty cells over NUM_CELLS/LANES cycles; define SCORE_WINNER_EN to add winner/board_full outputs
module score_scanner #(
    parameter int NUM_CELLS = 64,
    parameter int CELL_W = 3,
    parameter int LANES = 1,
    parameter logic [CELL_W-1:0] WHITE_CODE = 3'b110,
    parameter logic [CELL_W-1:0] BLACK_CODE = 3'b111,
    localparam int SCORE_W = $clog2(NUM_CELLS+1)
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        init,
    input  logic                        start,
    input  logic [NUM_CELLS*CELL_W-1:0] board,
    output logic                        busy,
    output logic                        done,
    output logic [SCORE_W-1:0]          score_white,
    output logic [SCORE_W-1:0]          score_black,
    output logic [SCORE_W-1:0]          score_empty
`ifdef SCORE_WINNER_EN
    ,
    output logic [1:0]                  winner,
    output logic                        board_full
`endif
);
    localparam int GROUPS = NUM_CELLS / LANES;
    localparam int IDX_W = GROUPS > 1 ? $clog2(GROUPS) : 1;
    localparam int STEP = LANES * CELL_W;
    typedef enum logic {IDLE, SCAN} state_t;
    state_t state, state_n;
    logic [NUM_CELLS*CELL_W-1:0] snap;
    logic [IDX_W-1:0] idx;
    logic [SCORE_W-1:0] acc_w, acc_b, grp_w, grp_b, tot_w, tot_b;
    logic accept, last;
    assign accept = state == IDLE && start;
    assign last = idx == IDX_W'(GROUPS-1);
    assign busy = state == SCAN;
    assign tot_w = acc_w + grp_w;
    assign tot_b = acc_b + grp_b;
    // state register; init aborts any scan
    always_ff @(posedge clk)
        state <= (!resetn) ? IDLE : state_n;
    // next state: init wins over start, last group returns to IDLE
    always_comb
        state_n = init ? IDLE : accept ? SCAN : (state == SCAN && last) ? IDLE : state;
    // hit counts for the group at the bottom of the shifting snapshot
    always_comb begin
        grp_w = '0;
        grp_b = '0;
        for (int l = 0; l < LANES; l++) begin
            grp_w = grp_w + SCORE_W'(snap[l*CELL_W +: CELL_W] == WHITE_CODE);
            grp_b = grp_b + SCORE_W'(snap[l*CELL_W +: CELL_W] == BLACK_CODE);
        end
    end
    // snapshot/accumulate datapath and published scores
    always_ff @(posedge clk) begin
        if (!resetn || init) begin
            done        <= 1'b0;
            score_white <= SCORE_W'(2);
            score_black <= SCORE_W'(2);
            score_empty <= SCORE_W'(NUM_CELLS-4);
`ifdef SCORE_WINNER_EN
            winner      <= 2'b00;
            board_full  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                snap  <= board;
                acc_w <= '0;
                acc_b <= '0;
                idx   <= '0;
            end else if (state == SCAN) begin
                snap  <= snap >> STEP;
                acc_w <= tot_w;
                acc_b <= tot_b;
                idx   <= idx + 1'b1;
                if (last) begin
                    done        <= 1'b1;
                    score_white <= tot_w;
                    score_black <= tot_b;
                    score_empty <= SCORE_W'(NUM_CELLS) - tot_w - tot_b;
`ifdef SCORE_WINNER_EN
                    winner      <= tot_w > tot_b ? 2'b01 : tot_b > tot_w ? 2'b10 : 2'b00;
                    board_full  <= tot_w + tot_b == SCORE_W'(NUM_CELLS);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_score_scanner.sv
// tb_score_scanner: random and directed scans of a 1-lane and a 4-lane scanner against a cell-counting model
module tb_score_scanner;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic init = 1'b0;
    logic [1:0] start = 2'b00;
    logic [191:0] board = '0;
    logic [1:0] busy, done;
    logic [6:0] sw [2];
    logic [6:0] sb [2];
    logic [6:0] se [2];
    logic [1:0] win [2];
    logic full [2];
    int n_assert = 0;
    int n_fail = 0;
    int groups [2] = '{64, 16};

    always #5 clk = ~clk;

    score_scanner #(.LANES(1)) u1 (
        .clk(clk), .resetn(resetn), .init(init), .start(start[0]), .board(board),
        .busy(busy[0]), .done(done[0]), .score_white(sw[0]), .score_black(sb[0]), .score_empty(se[0])
`ifdef SCORE_WINNER_EN
        , .winner(win[0]), .board_full(full[0])
`endif
    );
    score_scanner #(.LANES(4)) u4 (
        .clk(clk), .resetn(resetn), .init(init), .start(start[1]), .board(board),
        .busy(busy[1]), .done(done[1]), .score_white(sw[1]), .score_black(sb[1]), .score_empty(se[1])
`ifdef SCORE_WINNER_EN
        , .winner(win[1]), .board_full(full[1])
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [191:0] b, output int w, output int k);
        logic [2:0] c;
        w = 0;
        k = 0;
        for (int i = 0; i < 64; i++) begin
            c = b[i*3 +: 3];
            if (c == 3'b110) w++;
            if (c == 3'b111) k++;
        end
    endfunction

    task automatic check_scores(input int k, input int w, input int b);
        check($sformatf("white%0d", k), sw[k], w);
        check($sformatf("black%0d", k), sb[k], b);
        check($sformatf("empty%0d", k), se[k], 64 - w - b);
`ifdef SCORE_WINNER_EN
        check($sformatf("winner%0d", k), win[k], w > b ? 1 : b > w ? 2 : 0);
        check($sformatf("full%0d", k), full[k], (w + b == 64) ? 1 : 0);
`endif
    endtask

    task automatic wait_done(input int k, inout int cyc);
        while (!done[k] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic scan(input int k, input logic [191:0] b);
        int cyc = 0;
        int w, bl;
        board = b;
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        check("busy_after_accept", busy[k], 1);
        check("no_done_at_accept", done[k], 0);
        wait_done(k, cyc);
        check($sformatf("latency%0d", k), cyc, groups[k]);
        check("busy_falls", busy[k], 0);
        model(b, w, bl);
        check_scores(k, w, bl);
    endtask

    task automatic watch_no_done(input int k);
        int cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done[k]) cnt++;
        end
        check("spurious_done", cnt, 0);
    endtask

    function automatic logic [191:0] rand_board();
        logic [191:0] b;
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = 3'($urandom_range(0, 7));
        return b;
    endfunction

    initial begin
        logic [191:0] b, b0;
        int cells [64];
        int cyc, w, bl, j, t;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("reset_busy", busy[k], 0);
            check("reset_done", done[k], 0);
            check_scores(k, 2, 2);
        end
        resetn = 1'b1;
        b = '0;
        b[27*3 +: 3] = 3'b110;
        b[28*3 +: 3] = 3'b111;
        b[35*3 +: 3] = 3'b111;
        b[36*3 +: 3] = 3'b110;
        scan(0, b);
        check("start_pos_white", sw[0], 2);
        @(posedge clk);
        #1;
        check("done_one_cycle", done[0], 0);
        for (int i = 0; i < 64; i++) cells[i] = i < 40 ? 6 : 7;
        for (int i = 63; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = cells[i];
            cells[i] = cells[j];
            cells[j] = t;
        end
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = 3'(cells[i]);
        scan(1, b);
        check("full_white", sw[1], 40);
        check("full_empty", se[1], 0);
        for (int i = 0; i < 6; i++) scan(i % 2, rand_board());
        scan(1, rand_board());
        scan(1, rand_board());
        b0 = rand_board();
        board = b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        board = '1;
        cyc = 0;
        while (!done[0] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 5) start[0] = 1'b1;
            if (cyc == 6) start[0] = 1'b0;
        end
        check("snap_latency", cyc, 64);
        model(b0, w, bl);
        check_scores(0, w, bl);
        watch_no_done(0);
        board = rand_board();
        start[0] = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        start[0] = 1'b0;
        init = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        check("abort_busy", busy[0], 0);
        check("abort_done", done[0], 0);
        check_scores(0, 2, 2);
        watch_no_done(0);
        init = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        init = 1'b0;
        start[0] = 1'b0;
        check("init_priority", busy[0], 0);
        scan(0, rand_board());
        board = rand_board();
        start[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        start[1] = 1'b0;
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        check("rst_busy", busy[1], 0);
        check_scores(1, 2, 2);
        watch_no_done(1);
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = 3'b101;
        scan(1, b);
        check("invalid_empty", se[1], 64);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
